dnn_infer_ctrl: RTL and testbench

//  Sequencer wrapped around the fix16 sigmoid inference engine (dnn_sigmoid_fix16 and its top).

---
 rtl/dnn_infer_ctrl_if.sv | 30 +++
 rtl/dnn_infer_ctrl.sv | 132 +++++++++++++
 tb/tb_dnn_infer_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dnn_infer_ctrl_if.sv
// Request/result handshake plus engine control bundle for the inference sequencer.
// master = sequencer side, slave = requester/engine side.
interface dnn_infer_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [3:0]            res_digit;
    logic [DATA_WIDTH-1:0] res_score;
    logic                  res_err;
    logic                  eng_reset;
    logic                  eng_start;
    logic                  eng_done;
    logic [3:0]            eng_out_idx;
    logic [DATA_WIDTH-1:0] eng_out;

    modport master (
        input  req_valid, res_ready, eng_done, eng_out,
        output req_ready, res_valid, res_digit, res_score, res_err,
        output eng_reset, eng_start, eng_out_idx
    );

    modport slave (
        output req_valid, res_ready, eng_done, eng_out,
        input  req_ready, res_valid, res_digit, res_score, res_err,
        input  eng_reset, eng_start, eng_out_idx
    );
endinterface

// File: rtl/dnn_infer_ctrl.sv
// Sequencer around the sigmoid inference engine: clear, start, wait with timeout,
// argmax-scan the output neurons and hand back digit/score over valid/ready.
module dnn_infer_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input logic                clk,
    input logic                rst,
    dnn_infer_ctrl_if.master   bus
);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
    localparam logic [3:0] IdxLast = 4'(NUM_CLASSES - 1);
    localparam logic signed [DATA_WIDTH-1:0] MostNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StClr, StStart, StWait, StScan, StResult} state_e;

    state_e                       state_q, state_d;
    logic [TmoW-1:0]              tmo_q, tmo_d;
    logic [3:0]                   idx_q, idx_d;
    logic [3:0]                   best_idx_q, best_idx_d;
    logic signed [DATA_WIDTH-1:0] best_q, best_d;
    logic [3:0]                   digit_q, digit_d;
    logic signed [DATA_WIDTH-1:0] score_q, score_d;
    logic                         err_q, err_d;

    logic                         req_rdy, res_vld, eng_rst, eng_go;
    logic [3:0]                   out_idx;
    logic signed [DATA_WIDTH-1:0] eng_out_s;

    assign eng_out_s = signed'(bus.eng_out);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            tmo_q      <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            digit_q    <= '0;
            score_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
            digit_q    <= digit_d;
            score_q    <= score_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        digit_d    = digit_q;
        score_d    = score_q;
        err_d      = err_q;
        req_rdy    = 1'b0;
        res_vld    = 1'b0;
        eng_rst    = 1'b0;
        eng_go     = 1'b0;
        out_idx    = '0;

        unique case (state_q)
            StIdle: begin
                // Held low while rst is asserted so no request slips in during reset.
                req_rdy = rst;
                if (bus.req_valid && rst) state_d = StClr;
            end
            StClr: begin
                eng_rst = 1'b1;
                state_d = StStart;
            end
            StStart: begin
                eng_go  = 1'b1;
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Done has priority over the final timeout cycle.
                if (bus.eng_done) begin
                    state_d    = StScan;
                    idx_d      = '0;
                    best_d     = MostNeg;
                    best_idx_d = '0;
                end else if (tmo_q == TmoLast) begin
                    state_d = StResult;
                    err_d   = 1'b1;
                    digit_d = 4'hF;
                    score_d = '0;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StScan: begin
                out_idx = idx_q;
                if (eng_out_s > best_q) begin
                    best_d     = eng_out_s;
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == IdxLast) begin
                    state_d = StResult;
                    digit_d = best_idx_d;
                    score_d = best_d;
                    err_d   = 1'b0;
                end
            end
            StResult: begin
                res_vld = 1'b1;
                if (bus.res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req_ready   = req_rdy;
    assign bus.res_valid   = res_vld;
    assign bus.res_digit   = digit_q;
    assign bus.res_score   = score_q;
    assign bus.res_err     = err_q;
    assign bus.eng_reset   = eng_rst;
    assign bus.eng_start   = eng_go;
    assign bus.eng_out_idx = out_idx;
endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// Self-checking bench for dnn_infer_ctrl: behavioural engine model plus an argmax
// and latency reference computed directly from the request timing rules.
module tb_dnn_infer_ctrl;
    localparam int TMO  = 8;
    localparam int NCLS = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dnn_infer_ctrl_if #(.DATA_WIDTH(16)) bus ();

    dnn_infer_ctrl #(
        .DATA_WIDTH (16),
        .NUM_CLASSES(NCLS),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Engine model: after start, done rises lat+1 edges later; reset clears it.
    logic [15:0] outs [16];
    int   lat    = 0;
    int   cnt    = 0;
    logic busy   = 1'b0;
    logic done_m = 1'b0;
    logic stale  = 1'b0;

    always @(posedge clk) begin
        if (bus.eng_reset) begin
            done_m <= 1'b0;
            busy   <= 1'b0;
        end else if (bus.eng_start) begin
            busy <= 1'b1;
            cnt  <= lat;
        end else if (busy) begin
            if (cnt == 0) begin
                done_m <= 1'b1;
                busy   <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    assign bus.eng_done = done_m | stale;
    assign bus.eng_out  = outs[bus.eng_out_idx];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_argmax(output logic [3:0] d, output logic [15:0] s);
        int best;
        best = -32768;
        d    = 4'd0;
        for (int i = 0; i < NCLS; i++) begin
            if (int'($signed(outs[i])) > best) begin
                best = int'($signed(outs[i]));
                d    = 4'(i);
            end
        end
        s = 16'(best);
    endtask

    task automatic run_req(input int lat_i, input int hold, input bit stale_i, input string tag);
        int rk, sk, vk, kd, exp_vk, overlap, bad;
        logic [3:0]  ed;
        logic [15:0] es;
        logic        ee;
        lat   = lat_i;
        stale = stale_i;
        kd    = 4 + lat_i;  // first cycle after accept in which done is visible
        if (kd <= 2 + TMO) begin
            ref_argmax(ed, es);
            ee     = 1'b0;
            exp_vk = kd + NCLS + 1;
        end else begin
            ed     = 4'hF;
            es     = 16'h0;
            ee     = 1'b1;
            exp_vk = 3 + TMO;
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rk = -1; sk = -1; vk = -1; overlap = 0;
        for (int k = 1; k <= 60 && vk < 0; k++) begin
            @(negedge clk);
            if (bus.eng_reset && rk < 0) begin
                rk    = k;
                stale = 1'b0;
            end
            if (bus.eng_start && sk < 0) sk = k;
            if (bus.eng_reset && bus.eng_start) overlap++;
            if (bus.res_valid) vk = k;
        end
        stale = 1'b0;
        chk({tag, "_reset_cyc"}, 32'(rk), 32'd1);
        chk({tag, "_start_cyc"}, 32'(sk), 32'd2);
        chk({tag, "_valid_cyc"}, 32'(vk), 32'(exp_vk));
        chk({tag, "_overlap"}, 32'(overlap), 32'd0);
        chk({tag, "_digit"}, 32'(bus.res_digit), 32'(ed));
        chk({tag, "_score"}, 32'(bus.res_score), 32'(es));
        chk({tag, "_err"}, 32'(bus.res_err), 32'(ee));
        bad = 0;
        repeat (hold) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_digit !== ed || bus.res_score !== es ||
                bus.res_err !== ee) bad++;
        end
        chk({tag, "_hold_stable"}, 32'(bad), 32'd0);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int bad;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 16; i++) outs[i] = 16'h0;

        // Reset held for 3 cycles.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_eng_reset", 32'(bus.eng_reset), 32'd0);
        chk("rst_eng_start", 32'(bus.eng_start), 32'd0);
        chk("rst_out_idx", 32'(bus.eng_out_idx), 32'd0);
        chk("rst_fields", {bus.res_digit, bus.res_score, 11'd0, bus.res_err}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Directed: outs {1,2,9,3,...}, done at T+5, result held 20 cycles.
        outs[0] = 16'd1; outs[1] = 16'd2; outs[2] = 16'd9; outs[3] = 16'd3;
        for (int i = 4; i < NCLS; i++) outs[i] = 16'(i - 3);
        run_req(1, 20, 1'b0, "basic");

        // Tie between idx4 and idx7 at max positive.
        for (int i = 0; i < NCLS; i++) outs[i] = 16'h0100;
        outs[4] = 16'h7FFF; outs[7] = 16'h7FFF;
        run_req(2, 0, 1'b0, "tie");

        // All negative, max -5 at idx9.
        for (int i = 0; i < NCLS; i++) outs[i] = 16'(-100 - i);
        outs[9] = 16'hFFFB;
        run_req(0, 1, 1'b0, "neg");

        // All most-negative gives digit 0.
        for (int i = 0; i < NCLS; i++) outs[i] = 16'h8000;
        run_req(3, 0, 1'b0, "allmin");

        // Timeout, done exactly on last wait cycle, and one cycle too late.
        run_req(100, 2, 1'b0, "timeout");
        outs[6] = 16'h1234;
        run_req(6, 0, 1'b0, "lastcyc");
        run_req(7, 0, 1'b0, "late");

        // Stale done high before the request.
        outs[3] = 16'h4000;
        run_req(1, 0, 1'b1, "stale");

        // Reset in the middle of SCAN: no result may appear.
        lat = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.eng_reset !== 1'b0) bad++;
        end
        chk("midscan_no_result", 32'(bad), 32'd0);
        chk("midscan_idle", 32'(bus.req_ready), 32'd1);
        run_req(2, 0, 1'b0, "recover");

        // Randomized outputs and latencies, with occasional forced ties.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) outs[i] = 16'($urandom);
            if (r % 2 == 1) outs[$urandom_range(5, 9)] = outs[$urandom_range(0, 4)];
            run_req(int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
